// File: rtl/rob_flush_walker.sv
// rob_flush_walker: ROB recovery sequencer. Arbitrates branch-mispredict and
// memory-order-violation flushes, then walks the ROB from the youngest entry
// toward the flush target two entries per cycle. For each entry it issues a
// ROB kill, a RAT restore and a free-list return.
module rob_flush_walker #(
    parameter int ROB_SEL     = 6,
    parameter int REG_SEL     = 5,
    parameter int PHY_REG_SEL = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   prmiss,
    input  logic [ROB_SEL-1:0]     prmiss_rob_idx,
    input  logic                   violation_detected,
    input  logic [ROB_SEL-1:0]     violation_rob_idx,
    input  logic [ROB_SEL-1:0]     youngest_idx,
    output logic [ROB_SEL-1:0]     walk_idx_0,
    output logic [ROB_SEL-1:0]     walk_idx_1,
    input  logic                   rd_has_dst_0,
    input  logic                   rd_has_dst_1,
    input  logic [REG_SEL-1:0]     rd_dst_0,
    input  logic [REG_SEL-1:0]     rd_dst_1,
    input  logic [PHY_REG_SEL-1:0] rd_phy_ori_0,
    input  logic [PHY_REG_SEL-1:0] rd_phy_ori_1,
    input  logic [PHY_REG_SEL-1:0] rd_phy_new_0,
    input  logic [PHY_REG_SEL-1:0] rd_phy_new_1,
    output logic                   kill_valid_0,
    output logic                   kill_valid_1,
    output logic                   rat_restore_valid_0,
    output logic                   rat_restore_valid_1,
    output logic [REG_SEL-1:0]     rat_restore_arch_0,
    output logic [REG_SEL-1:0]     rat_restore_arch_1,
    output logic [PHY_REG_SEL-1:0] rat_restore_phy_0,
    output logic [PHY_REG_SEL-1:0] rat_restore_phy_1,
    output logic                   fl_free_valid_0,
    output logic                   fl_free_valid_1,
    output logic [PHY_REG_SEL-1:0] fl_free_phy_0,
    output logic [PHY_REG_SEL-1:0] fl_free_phy_1,
    output logic                   busy,
    output logic                   done,
    output logic [ROB_SEL:0]       kill_cnt,
    output logic [ROB_SEL-1:0]     new_youngest_idx
);

    localparam int CW = ROB_SEL + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ROB_SEL-1:0] y0_q, y0_d;
    logic [ROB_SEL-1:0] ptr_q, ptr_d;
    logic [CW-1:0]      end_cnt_q, end_cnt_d;
    logic [CW-1:0]      done_cnt_q, done_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [ROB_SEL-1:0] ref_idx, dist_p, dist_v;
    logic [CW-1:0]      cp, cv, req_cnt, rem, n_lanes;
    logic               any_req, lane0, lane1;

    // Candidate kill counts measured from the youngest reference; larger wins.
    always_comb begin
        ref_idx = (state_q == ST_IDLE) ? youngest_idx : y0_q;
        dist_p  = prmiss_rob_idx - ref_idx;
        dist_v  = violation_rob_idx - ref_idx;
        cp      = {1'b0, dist_p};
        cv      = {1'b0, dist_v} + CW'(1);
        any_req = prmiss | violation_detected;
        req_cnt = '0;
        if (prmiss && violation_detected) begin
            req_cnt = (cv > cp) ? cv : cp;
        end else if (prmiss) begin
            req_cnt = cp;
        end else if (violation_detected) begin
            req_cnt = cv;
        end
    end

    // Lane activity derived purely from registered walk progress.
    always_comb begin
        rem     = end_cnt_q - done_cnt_q;
        lane0   = (state_q == ST_WALK) && (rem >= CW'(1));
        lane1   = (state_q == ST_WALK) && (rem >= CW'(2));
        n_lanes = CW'(lane0) + CW'(lane1);
    end

    // Next-state logic: capture in IDLE, advance in WALK, extend on a deeper request.
    always_comb begin
        state_d    = state_q;
        y0_d       = y0_q;
        ptr_d      = ptr_q;
        end_cnt_d  = end_cnt_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    y0_d       = youngest_idx;
                    ptr_d      = youngest_idx;
                    end_cnt_d  = req_cnt;
                    done_cnt_d = '0;
                    state_d    = (req_cnt != '0) ? ST_WALK : ST_DONE;
                end
            end
            ST_WALK: begin
                ptr_d      = ptr_q + n_lanes[ROB_SEL-1:0];
                done_cnt_d = done_cnt_q + n_lanes;
                if (rem == n_lanes) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A deeper request mid-recovery extends the walk from where it stands;
        // y0/ptr stay put so no entry is revisited.
        if (state_q != ST_IDLE && any_req && (req_cnt > end_cnt_q)) begin
            end_cnt_d = req_cnt;
            state_d   = ST_WALK;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            y0_q       <= '0;
            ptr_q      <= '0;
            end_cnt_q  <= '0;
            done_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            y0_q       <= y0_d;
            ptr_q      <= ptr_d;
            end_cnt_q  <= end_cnt_d;
            done_cnt_q <= done_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Per-lane kill, RAT restore and free-list outputs.
    always_comb begin
        walk_idx_0          = ptr_q;
        walk_idx_1          = ptr_q + ROB_SEL'(1);
        kill_valid_0        = lane0;
        kill_valid_1        = lane1;
        rat_restore_valid_0 = lane0 & rd_has_dst_0;
        rat_restore_valid_1 = lane1 & rd_has_dst_1;
        fl_free_valid_0     = lane0 & rd_has_dst_0;
        fl_free_valid_1     = lane1 & rd_has_dst_1;
        rat_restore_arch_0  = rd_dst_0;
        rat_restore_arch_1  = rd_dst_1;
        rat_restore_phy_0   = rd_phy_ori_0;
        rat_restore_phy_1   = rd_phy_ori_1;
        fl_free_phy_0       = rd_phy_new_0;
        fl_free_phy_1       = rd_phy_new_1;
        busy                = busy_q;
        done                = done_q;
        kill_cnt            = done_q ? done_cnt_q : '0;
        new_youngest_idx    = done_q ? (y0_q + done_cnt_q[ROB_SEL-1:0]) : '0;
    end

endmodule

// File: tb/tb_rob_flush_walker.sv
// tb_rob_flush_walker: directed flushes against a small ROB content table;
// expected kills and done records are queued by the stimulus and consumed by
// a negedge monitor.
module tb_rob_flush_walker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       prmiss = 1'b0;
    logic [5:0] prmiss_rob_idx = '0;
    logic       violation_detected = 1'b0;
    logic [5:0] violation_rob_idx = '0;
    logic [5:0] youngest_idx = '0;
    logic [5:0] walk_idx_0, walk_idx_1;
    logic       rd_has_dst_0, rd_has_dst_1;
    logic [4:0] rd_dst_0, rd_dst_1;
    logic [5:0] rd_phy_ori_0, rd_phy_ori_1, rd_phy_new_0, rd_phy_new_1;
    logic       kill_valid_0, kill_valid_1;
    logic       rat_restore_valid_0, rat_restore_valid_1;
    logic [4:0] rat_restore_arch_0, rat_restore_arch_1;
    logic [5:0] rat_restore_phy_0, rat_restore_phy_1;
    logic       fl_free_valid_0, fl_free_valid_1;
    logic [5:0] fl_free_phy_0, fl_free_phy_1;
    logic       busy, done;
    logic [6:0] kill_cnt;
    logic [5:0] new_youngest_idx;

    rob_flush_walker #(
        .ROB_SEL(6),
        .REG_SEL(5),
        .PHY_REG_SEL(6)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .prmiss(prmiss), .prmiss_rob_idx(prmiss_rob_idx),
        .violation_detected(violation_detected), .violation_rob_idx(violation_rob_idx),
        .youngest_idx(youngest_idx),
        .walk_idx_0(walk_idx_0), .walk_idx_1(walk_idx_1),
        .rd_has_dst_0(rd_has_dst_0), .rd_has_dst_1(rd_has_dst_1),
        .rd_dst_0(rd_dst_0), .rd_dst_1(rd_dst_1),
        .rd_phy_ori_0(rd_phy_ori_0), .rd_phy_ori_1(rd_phy_ori_1),
        .rd_phy_new_0(rd_phy_new_0), .rd_phy_new_1(rd_phy_new_1),
        .kill_valid_0(kill_valid_0), .kill_valid_1(kill_valid_1),
        .rat_restore_valid_0(rat_restore_valid_0), .rat_restore_valid_1(rat_restore_valid_1),
        .rat_restore_arch_0(rat_restore_arch_0), .rat_restore_arch_1(rat_restore_arch_1),
        .rat_restore_phy_0(rat_restore_phy_0), .rat_restore_phy_1(rat_restore_phy_1),
        .fl_free_valid_0(fl_free_valid_0), .fl_free_valid_1(fl_free_valid_1),
        .fl_free_phy_0(fl_free_phy_0), .fl_free_phy_1(fl_free_phy_1),
        .busy(busy), .done(done),
        .kill_cnt(kill_cnt), .new_youngest_idx(new_youngest_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROB contents seen by the walker, and a RAT image built from restores.
    logic       has_m [64];
    logic [4:0] dst_m [64];
    logic [5:0] ori_m [64];
    logic [5:0] new_m [64];
    logic [5:0] rat_m [32];

    always_comb begin
        rd_has_dst_0 = has_m[walk_idx_0];
        rd_has_dst_1 = has_m[walk_idx_1];
        rd_dst_0     = dst_m[walk_idx_0];
        rd_dst_1     = dst_m[walk_idx_1];
        rd_phy_ori_0 = ori_m[walk_idx_0];
        rd_phy_ori_1 = ori_m[walk_idx_1];
        rd_phy_new_0 = new_m[walk_idx_0];
        rd_phy_new_1 = new_m[walk_idx_1];
    end

    typedef struct {
        int         cyc;
        int         lane;
        logic [5:0] idx;
        logic       rv;
        logic [4:0] arch;
        logic [5:0] ori;
        logic [5:0] nw;
    } kill_exp_t;

    typedef struct {
        int         cyc;
        logic [6:0] cnt;
        logic [5:0] ny;
    } done_exp_t;

    kill_exp_t kq[$];
    done_exp_t dq[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_walk(input int start, input int cnt, input int first_cyc);
        for (int i = 0; i < cnt; i++) begin
            kill_exp_t  e;
            logic [5:0] ix;
            ix     = 6'(start + i);
            e.cyc  = first_cyc + i / 2;
            e.lane = i % 2;
            e.idx  = ix;
            e.rv   = has_m[ix];
            e.arch = dst_m[ix];
            e.ori  = ori_m[ix];
            e.nw   = new_m[ix];
            kq.push_back(e);
        end
    endtask

    task automatic push_done(input int c, input int cnt, input int ny);
        done_exp_t d;
        d.cyc = c;
        d.cnt = 7'(cnt);
        d.ny  = 6'(ny);
        dq.push_back(d);
    endtask

    task automatic lane_chk(input int k, input logic [5:0] widx, input logic rv,
                            input logic [4:0] ra, input logic [5:0] rp,
                            input logic fv, input logic [5:0] fp);
        kill_exp_t e;
        if (kq.size() == 0) begin
            check("unexpected_kill", 64'(widx), 64'hFFFF);
            return;
        end
        e = kq.pop_front();
        check("kill_idx", 64'(widx), 64'(e.idx));
        check("kill_cycle", 64'(cyc), 64'(e.cyc));
        check("kill_lane", 64'(k), 64'(e.lane));
        check("rat_valid", 64'(rv), 64'(e.rv));
        check("fl_valid", 64'(fv), 64'(e.rv));
        if (e.rv) begin
            check("rat_arch", 64'(ra), 64'(e.arch));
            check("rat_phy", 64'(rp), 64'(e.ori));
            check("fl_phy", 64'(fp), 64'(e.nw));
        end
        if (rv) rat_m[ra] = rp;
    endtask

    // Monitor: consumes expectations whenever the DUT presents kills or done.
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_done = 1'b0;
            check("outputs_in_reset",
                  64'({kill_valid_0, kill_valid_1, rat_restore_valid_0, rat_restore_valid_1,
                       fl_free_valid_0, fl_free_valid_1, busy, done}), 64'(0));
        end else begin
            while (kq.size() > 0 && kq[0].cyc < cyc) begin
                check("missed_kill", 64'(kq[0].idx), 64'hFFFF);
                void'(kq.pop_front());
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                check("missed_done", 64'(dq[0].cyc), 64'hFFFF);
                void'(dq.pop_front());
            end
            if (prev_done) check("busy_after_done", 64'(busy), 64'(0));
            if (kill_valid_0)
                lane_chk(0, walk_idx_0, rat_restore_valid_0, rat_restore_arch_0,
                         rat_restore_phy_0, fl_free_valid_0, fl_free_phy_0);
            else
                check("idle_lane0_valids", 64'({rat_restore_valid_0, fl_free_valid_0, kill_valid_1}), 64'(0));
            if (kill_valid_1)
                lane_chk(1, walk_idx_1, rat_restore_valid_1, rat_restore_arch_1,
                         rat_restore_phy_1, fl_free_valid_1, fl_free_phy_1);
            else
                check("idle_lane1_valids", 64'({rat_restore_valid_1, fl_free_valid_1}), 64'(0));
            if (done) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", 64'(kill_cnt), 64'hFFFF);
                end else begin
                    done_exp_t d;
                    d = dq.pop_front();
                    check("done_cycle", 64'(cyc), 64'(d.cyc));
                    check("kill_cnt", 64'(kill_cnt), 64'(d.cnt));
                    check("new_youngest_idx", 64'(new_youngest_idx), 64'(d.ny));
                    check("busy_at_done", 64'(busy), 64'(1));
                end
            end
            prev_done = done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic p, input int pi, input logic v, input int vi, input int y);
        prmiss             = p;
        prmiss_rob_idx     = 6'(pi);
        violation_detected = v;
        violation_rob_idx  = 6'(vi);
        youngest_idx       = 6'(y);
    endtask

    task automatic clr();
        prmiss             = 1'b0;
        violation_detected = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy && kq.size() == 0 && dq.size() == 0) return;
        end
        check("wait_idle_timeout", 64'(busy), 64'(0));
        kq.delete();
        dq.delete();
    endtask

    // One flush with hand-computed kill count and new youngest index.
    task automatic flush(input logic p, input int pi, input logic v, input int vi,
                         input int y, input int cnt, input int ny);
        int c;
        step();
        c = cyc;
        check("idle_before_req", 64'(busy), 64'(0));
        req(p, pi, v, vi, y);
        push_walk(y, cnt, c + 1);
        push_done(c + 1 + (cnt + 1) / 2, cnt, ny);
        step();
        clr();
        check("busy_after_capture", 64'(busy), 64'(1));
        wait_idle(100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 64; i++) begin
            has_m[i] = (i % 5 != 4);
            dst_m[i] = 5'(i);
            ori_m[i] = 6'(i) ^ 6'h2A;
            new_m[i] = ~6'(i);
        end
        dst_m[40] = 5'd7;
        dst_m[41] = 5'd7;
        for (int i = 0; i < 32; i++) rat_m[i] = '0;

        #1 reset_n = 1'b0;
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_kill_cnt", 64'(kill_cnt), 64'(0));
        check("reset_new_youngest", 64'(new_youngest_idx), 64'(0));
        check("reset_valids", 64'({kill_valid_0, kill_valid_1, rat_restore_valid_0,
                                   rat_restore_valid_1, fl_free_valid_0, fl_free_valid_1}), 64'(0));
        step();
        step();
        reset_n = 1'b1;

        flush(1'b1, 15, 1'b0, 0, 10, 5, 15);   // basic, entry 14 has no dst
        flush(1'b0, 0, 1'b1, 1, 62, 4, 2);     // wrap, inclusive violation
        flush(1'b1, 20, 1'b1, 20, 18, 3, 21);  // equal targets: violation wins
        flush(1'b1, 25, 1'b1, 21, 18, 7, 25);  // prmiss deeper
        flush(1'b1, 33, 1'b0, 0, 33, 0, 33);   // zero-count flush
        flush(1'b0, 0, 1'b1, 19, 20, 64, 20);  // full ROB flush

        // Same arch on both lanes: older lane 1 must land last.
        rat_m[7] = '0;
        flush(1'b1, 42, 1'b0, 0, 40, 2, 42);
        check("rat_same_arch", 64'(rat_m[7]), 64'(6'd41 ^ 6'h2A));

        // Retarget deeper mid-walk; youngest_idx changes to prove y0 is used.
        step();
        c = cyc;
        req(1'b1, 8, 1'b0, 0, 0);
        push_walk(0, 30, c + 1);
        push_done(c + 16, 30, 30);
        step();
        clr();
        youngest_idx = 6'd3;
        step();
        req(1'b1, 30, 1'b0, 0, 3);
        step();
        clr();
        wait_idle(100);

        // Shallower request mid-walk is ignored.
        step();
        c = cyc;
        req(1'b1, 8, 1'b0, 0, 0);
        push_walk(0, 8, c + 1);
        push_done(c + 5, 8, 8);
        step();
        clr();
        youngest_idx = 6'd3;
        step();
        req(1'b1, 4, 1'b0, 0, 3);
        step();
        clr();
        wait_idle(100);

        // Reset in walk cycle 2 of a 10-entry flush.
        step();
        c = cyc;
        req(1'b1, 60, 1'b0, 0, 50);
        push_walk(50, 2, c + 1);
        step();
        clr();
        step();
        #1 reset_n = 1'b0;
        #1;
        check("midwalk_reset_busy", 64'(busy), 64'(0));
        check("midwalk_reset_kill", 64'({kill_valid_0, kill_valid_1}), 64'(0));
        check("midwalk_reset_done", 64'(done), 64'(0));
        step();
        step();
        reset_n = 1'b1;
        step();
        check("post_reset_idle", 64'(busy), 64'(0));
        check("post_reset_kq_empty", 64'(kq.size()), 64'(0));
        flush(1'b1, 9, 1'b0, 0, 5, 4, 9);

        check("final_kq_empty", 64'(kq.size()), 64'(0));
        check("final_dq_empty", 64'(dq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
